// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader uses the slave modport; the source/memory side uses master.
interface imem_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [31:0] imem_test_addr;
   logic [31:0] imem_test_data;
   logic        imem_wr_en;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output imem_test_addr,
      output imem_test_data,
      output imem_wr_en
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  imem_test_addr,
      input  imem_test_data,
      input  imem_wr_en
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: LEN_LO, LEN_HI, then N little-endian words written to instrMem.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter int          MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'd0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   imem_loader_if.slave bus,
   output logic         busy_o,
   output logic         done_o,
   output logic         cpu_run_o,
   output logic         error_o
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN0  = 3'd1;
   localparam logic [2:0] ST_LEN1  = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_WRITE = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;
   localparam logic [2:0] ST_FAIL  = 3'd6;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_CHK   = 3'd7;
   localparam logic [2:0] ST_LAST  = ST_CHK;
`else
   localparam logic [2:0] ST_LAST  = ST_DONE;
`endif

   logic [2:0]  state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [15:0] idx_q, idx_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] word_q, word_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  xor_q, xor_d;
`endif

   logic        ready;
   logic        xfer;
   logic [15:0] len;
   logic [15:0] idx_inc;

`ifdef LOADER_CHECKSUM_EN
   assign ready = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                  (state_q == ST_DATA) || (state_q == ST_CHK);
`else
   assign ready = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                  (state_q == ST_DATA);
`endif
   assign xfer    = bus.in_valid && ready;
   assign len     = {bus.in_data, n_q[7:0]};
   assign idx_inc = idx_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      idx_d      = idx_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      addr_d     = addr_q;
      data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
      xor_d      = xor_q;
      if (xfer && (state_q != ST_CHK)) begin
         xor_d = xor_q ^ bus.in_data;
      end
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start_i) begin
               state_d    = ST_LEN0;
               idx_d      = 16'd0;
               byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
               xor_d      = 8'd0;
`endif
            end
         end
         ST_LEN0: begin
            if (xfer) begin
               n_d[7:0] = bus.in_data;
               state_d  = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (xfer) begin
               n_d = len;
               if (len > 16'(MAX_WORDS)) begin
                  state_d = ST_FAIL;
               end else if (len == 16'd0) begin
                  state_d = ST_LAST;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0:    word_d[7:0]   = bus.in_data;
                  2'd1:    word_d[15:8]  = bus.in_data;
                  2'd2:    word_d[23:16] = bus.in_data;
                  default: begin
                     // Output registers only change here, so they hold between writes.
                     addr_d  = BASE_ADDR + {16'd0, idx_q};
                     data_d  = {bus.in_data, word_q};
                     state_d = ST_WRITE;
                  end
               endcase
            end
         end
         ST_WRITE: begin
            idx_d   = idx_inc;
            state_d = (idx_inc == n_q) ? ST_LAST : ST_DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (xfer) begin
               state_d = (bus.in_data == xor_q) ? ST_DONE : ST_FAIL;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         n_q        <= 16'd0;
         idx_q      <= 16'd0;
         byte_cnt_q <= 2'd0;
         word_q     <= 24'd0;
         addr_q     <= 32'd0;
         data_q     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         xor_q      <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end

   assign bus.in_ready       = ready;
   assign bus.imem_wr_en     = (state_q == ST_WRITE);
   assign bus.imem_test_addr = addr_q;
   assign bus.imem_test_data = data_q;
   assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_FAIL);
   assign done_o    = (state_q == ST_DONE);
   assign cpu_run_o = (state_q == ST_DONE);
   assign error_o   = (state_q == ST_FAIL);

endmodule
